// File: rtl/uart_arbiter_if.sv
// Requester and uart_controller signals shared by uart_arbiter; slave is the arbiter side.
// Combinational bundle only: no latency, commands are held by the requester until done/err.
interface uart_arbiter_if;
  logic [1:0]  r0_cmd;
  logic [15:0] r0_data;
  logic        r0_done;
  logic        r0_err;
  logic [1:0]  r1_cmd;
  logic [15:0] r1_data;
  logic        r1_done;
  logic        r1_err;
  logic [7:0]  rd_data;
  logic        u_wr_en;
  logic        u_read;
  logic        u_baud_wr;
  logic [15:0] u_data;
  logic [7:0]  u_data_out;
  logic        u_wait;
  logic        busy;

  modport slave (
    input  r0_cmd, r0_data, r1_cmd, r1_data, u_data_out, u_wait,
    output r0_done, r0_err, r1_done, r1_err, rd_data,
    output u_wr_en, u_read, u_baud_wr, u_data, busy
  );

  modport master (
    output r0_cmd, r0_data, r1_cmd, r1_data, u_data_out, u_wait,
    input  r0_done, r0_err, r1_done, r1_err, rd_data,
    input  u_wr_en, u_read, u_baud_wr, u_data, busy
  );
endinterface

// File: rtl/uart_arbiter.sv
// Round-robin arbiter serialising two held-command requesters onto one uart_controller.
// Write/baud done 4 cycles after grant, read 4 + wait cycles; rejected writes retried, loser's cmd just waits.
module uart_arbiter #(
  parameter int RETRY_GAP   = 2,
  parameter int MAX_RETRIES = 255
) (
  input  logic           clk,
  input  logic           rst,
  uart_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, SETTLE, CHECK, GAP, DONE, ERR
  } state_t;

  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_RD   = 2'b10;
  localparam logic [1:0] CMD_BAUD = 2'b11;
  localparam logic [7:0] MAX_R    = 8'(MAX_RETRIES);
  localparam logic [7:0] GAP_LAST = 8'(RETRY_GAP - 1);

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        win;
  logic [7:0]  retry_inc;
  logic        pend0, pend1;

  assign pend0 = (bus.r0_cmd != 2'b00);
  assign pend1 = (bus.r1_cmd != 2'b00);

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_grant_d  = last_grant_q;
    cmd_d         = cmd_q;
    data_d        = data_q;
    retry_d       = retry_q;
    gap_d         = gap_q;
    rd_data_d     = rd_data_q;
    win           = 1'b0;
    retry_inc     = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
    bus.u_wr_en   = 1'b0;
    bus.u_read    = 1'b0;
    bus.u_baud_wr = 1'b0;
    bus.r0_done   = 1'b0;
    bus.r0_err    = 1'b0;
    bus.r1_done   = 1'b0;
    bus.r1_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend0 || pend1) begin
          // On a tie the requester not served last wins; otherwise whoever is pending.
          win     = (pend0 && pend1) ? ~last_grant_q : pend1;
          gnt_d   = win;
          cmd_d   = win ? bus.r1_cmd : bus.r0_cmd;
          data_d  = win ? bus.r1_data : bus.r0_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.u_wr_en   = (cmd_q == CMD_WR);
        bus.u_read    = (cmd_q == CMD_RD);
        bus.u_baud_wr = (cmd_q == CMD_BAUD);
        state_d       = SETTLE;
      end
      SETTLE: state_d = CHECK;
      CHECK: begin
        case (cmd_q)
          CMD_WR: begin
            if (!bus.u_wait) begin
              state_d = DONE;
            end else begin
              retry_d = retry_inc;
              if (MAX_R != 8'd0 && retry_inc >= MAX_R) begin
                state_d = ERR;
              end else begin
                gap_d   = 8'd0;
                state_d = GAP;
              end
            end
          end
          CMD_RD: begin
            if (!bus.u_wait) begin
              rd_data_d = bus.u_data_out;
              state_d   = DONE;
            end
          end
          default: state_d = DONE;
        endcase
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ISSUE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      DONE: begin
        bus.r0_done  = ~gnt_q;
        bus.r1_done  = gnt_q;
        last_grant_d = gnt_q;
        retry_d      = 8'd0;
        state_d      = IDLE;
      end
      ERR: begin
        bus.r0_err   = ~gnt_q;
        bus.r1_err   = gnt_q;
        last_grant_d = gnt_q;
        retry_d      = 8'd0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.u_data  = (state_q != IDLE) ? data_q : 16'h0000;
  assign bus.rd_data = rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_q        <= 2'b00;
      data_q       <= 16'h0000;
      retry_q      <= 8'd0;
      gap_q        <= 8'd0;
      rd_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      retry_q      <= retry_d;
      gap_q        <= gap_d;
      rd_data_q    <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter: directed requests, a small uart_controller stand-in, and a cycle-stamped scoreboard.
// Expected strobe/done/err events are queued by the stimulus and popped by an independent monitor.
module tb_uart_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_arbiter_if bus();

  uart_arbiter #(.RETRY_GAP(2), .MAX_RETRIES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller stand-in: uart_wait high for the one cycle two after a read strobe, or always when TX is full.
  logic       tx_full = 1'b0;
  logic       wait_q  = 1'b0;
  logic [1:0] stage   = 2'd0;
  logic [7:0] data_out_v = 8'h00;
  always @(posedge clk) begin
    if (bus.u_read) begin
      stage <= 2'd1;
    end else if (stage == 2'd1) begin
      wait_q <= 1'b1;
      stage  <= 2'd2;
    end else if (stage == 2'd2) begin
      wait_q <= 1'b0;
      stage  <= 2'd0;
    end
  end
  assign bus.u_wait     = wait_q | tx_full;
  assign bus.u_data_out = data_out_v;

  // kind: 0 wr, 1 rd, 2 baud, 3 r0_done, 4 r1_done, 5 r0_err, 6 r1_err
  typedef struct {
    int          kind;
    logic [15:0] val;
    int          cyc;
  } ev_t;
  ev_t exp_q[$];

  int   checks   = 0;
  int   failures = 0;
  logic fin0 = 1'b0;
  logic fin1 = 1'b0;
  logic [7:0] last_rd = 8'h00;

  function automatic void exp_ev(input int kind, input logic [15:0] val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    int          kind;
    logic [15:0] val;
    ev_t         e;
    kind = -1;
    val  = 16'h0000;
    if (bus.u_wr_en)        begin kind = 0; val = bus.u_data; end
    else if (bus.u_read)    begin kind = 1; val = bus.u_data; end
    else if (bus.u_baud_wr) begin kind = 2; val = bus.u_data; end
    else if (bus.r0_done)   begin kind = 3; val = {8'h00, bus.rd_data}; end
    else if (bus.r1_done)   begin kind = 4; val = {8'h00, bus.rd_data}; end
    else if (bus.r0_err)    begin kind = 5; end
    else if (bus.r1_err)    begin kind = 6; end
    if (bus.r0_done || bus.r0_err) fin0 = 1'b1;
    if (bus.r1_done || bus.r1_err) fin1 = 1'b1;
    if (kind >= 0) begin
      checks++;
      if ($countones({bus.u_wr_en, bus.u_read, bus.u_baud_wr,
                      bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err}) != 1) begin
        failures++;
        $display("FAIL onehot cyc=%0d wr=%b rd=%b baud=%b d0=%b d1=%b e0=%b e1=%b", cyc,
                 bus.u_wr_en, bus.u_read, bus.u_baud_wr, bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got kind=%0d val=%h, required none", cyc, kind, val);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.val !== val) begin
          failures++;
          $display("FAIL event got kind=%0d val=%h cyc=%0d, required kind=%0d val=%h cyc=%0d",
                   kind, val, cyc, e.kind, e.val, e.cyc);
        end
      end
    end
  end

  task automatic post(input int id, input logic [1:0] cmd, input logic [15:0] data);
    bit got;
    got = 1'b0;
    if (id == 0) begin fin0 = 1'b0; bus.r0_cmd = cmd; bus.r0_data = data; end
    else         begin fin1 = 1'b0; bus.r1_cmd = cmd; bus.r1_data = data; end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if ((id == 0) ? fin0 : fin1) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    if (id == 0) bus.r0_cmd = 2'b00;
    else         bus.r1_cmd = 2'b00;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL complete_r%0d no done/err within 100 cycles, required one", id);
    end
  endtask

  task automatic check_idle(input string name);
    logic [31:0] got;
    got = {bus.busy, bus.u_wr_en, bus.u_read, bus.u_baud_wr, bus.r0_done, bus.r0_err,
           bus.r1_done, bus.r1_err, bus.rd_data, bus.u_data};
    checks++;
    if (got != 32'h0) begin
      failures++;
      $display("FAIL %s outputs=%h, required 0", name, got);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.r0_cmd = 2'b00;
    bus.r1_cmd = 2'b00;
    idle_cycles(2);
    rst = 1'b0;
    last_rd = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    bus.r0_cmd = 2'b00; bus.r0_data = 16'h0000;
    bus.r1_cmd = 2'b00; bus.r1_data = 16'h0000;
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    check_idle("reset_state");

    // r0 write; data change after grant must be ignored
    c = cyc;
    exp_ev(0, 16'h0041, c + 1);
    exp_ev(3, {8'h00, last_rd}, c + 4);
    fork
      post(0, 2'b01, 16'h0041);
      begin @(posedge clk); #1; bus.r0_data = 16'hFFFF; end
    join
    idle_cycles(2);

    // r1 read, controller waits one cycle
    data_out_v = 8'h5A;
    c = cyc;
    exp_ev(1, 16'h0000, c + 1);
    exp_ev(4, 16'h005A, c + 5);
    post(1, 2'b10, 16'h0000);
    last_rd = 8'h5A;
    idle_cycles(3);
    checks++;
    if (bus.rd_data !== 8'h5A) begin
      failures++;
      $display("FAIL rd_data_hold got=%h, required 5a", bus.rd_data);
    end

    // r1 baud
    c = cyc;
    exp_ev(2, 16'h006C, c + 1);
    exp_ev(4, {8'h00, last_rd}, c + 4);
    post(1, 2'b11, 16'h006C);
    idle_cycles(2);

    // tie after reset: r0 first, r1 waits and is served straight after
    reset_dut();
    data_out_v = 8'h33;
    c = cyc;
    exp_ev(0, 16'h0011, c + 1);
    exp_ev(3, 16'h0000, c + 4);
    exp_ev(1, 16'h0000, c + 6);
    exp_ev(4, 16'h0033, c + 10);
    fork
      post(0, 2'b01, 16'h0011);
      post(1, 2'b10, 16'h0000);
    join
    last_rd = 8'h33;
    idle_cycles(2);

    // r0 alone, so the next tie goes to r1
    c = cyc;
    exp_ev(0, 16'h0022, c + 1);
    exp_ev(3, 16'h0033, c + 4);
    post(0, 2'b01, 16'h0022);
    idle_cycles(2);

    data_out_v = 8'h99;
    c = cyc;
    exp_ev(1, 16'h0000, c + 1);
    exp_ev(4, 16'h0099, c + 5);
    exp_ev(0, 16'h0044, c + 7);
    exp_ev(3, 16'h0099, c + 10);
    fork
      post(0, 2'b01, 16'h0044);
      post(1, 2'b10, 16'h0000);
    join
    last_rd = 8'h99;
    idle_cycles(2);

    // TX full: three issues 5 cycles apart, then err
    tx_full = 1'b1;
    c = cyc;
    exp_ev(0, 16'h0055, c + 1);
    exp_ev(0, 16'h0055, c + 6);
    exp_ev(0, 16'h0055, c + 11);
    exp_ev(5, 16'h0000, c + 14);
    post(0, 2'b01, 16'h0055);
    tx_full = 1'b0;
    idle_cycles(2);

    // reset during GAP, then the re-posted write completes
    tx_full = 1'b1;
    c = cyc;
    exp_ev(0, 16'h0077, c + 1);
    bus.r0_cmd  = 2'b01;
    bus.r0_data = 16'h0077;
    idle_cycles(4);
    rst = 1'b1;
    idle_cycles(1);
    check_idle("reset_in_gap");
    rst = 1'b0;
    bus.r0_cmd = 2'b00;
    tx_full = 1'b0;
    last_rd = 8'h00;
    idle_cycles(3);
    check_idle("idle_after_reset");
    c = cyc;
    exp_ev(0, 16'h0077, c + 1);
    exp_ev(3, 16'h0000, c + 4);
    post(0, 2'b01, 16'h0077);

    idle_cycles(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
